// File: rtl/div_iter_unit_pkg.sv
// Shared types and sizing for the iterative restoring divider.
// Optional feature macro used by this slice: DIV_ZERO_DETECT_EN.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter_unit_if.sv
// Request/result interface between the control FSM (master) and the divider (slave).
// The dz flag exists only when DIV_ZERO_DETECT_EN is defined.
interface div_iter_unit_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             lo_we;
  logic             hi_we;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, q, r, lo_we, hi_we, dz
  );
  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, q, r, lo_we, hi_we, dz
  );
`else
  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, q, r, lo_we, hi_we
  );
  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, q, r, lo_we, hi_we
  );
`endif
endinterface

// File: rtl/div_iter_unit_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // The extra top bit carries the shifted-out remainder MSB into the compare.
    rem_sh = {rem, quo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, divisor});
    diff   = rem_sh[WIDTH-1:0] - divisor;
    if (ge) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle DIV/DIVU unit writing quotient to Lo and remainder to Hi.
// Optional divide-by-zero early exit: DIV_ZERO_DETECT_EN.
module div_iter_unit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  div_iter_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             neg_a, neg_b;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz_q, dz_d;
`endif

  assign neg_a = bus.is_signed & bus.dividend[WIDTH-1];
  assign neg_b = bus.is_signed & bus.divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dsr_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    q_d       = q_q;
    r_d       = r_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dz_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          quo_d     = neg_a ? -bus.dividend : bus.dividend;
          dsr_d     = neg_b ? -bus.divisor  : bus.divisor;
          rem_d     = '0;
          cnt_d     = '0;
          quo_neg_d = neg_a ^ neg_b;
          rem_neg_d = neg_a;
          busy_d    = 1'b1;
          state_d   = CALC;
`ifdef DIV_ZERO_DETECT_EN
          // Skip the iteration entirely and leave Hi/Lo untouched.
          if (bus.divisor == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            q_d     = '0;
            r_d     = '0;
          end
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d     = quo_neg_q ? -quo_q : quo_q;
        r_d     = rem_neg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        we_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      q_q       <= q_d;
      r_q       <= r_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.lo_we = we_q;
  assign bus.hi_we = we_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.dz    = dz_q;
`endif

endmodule
